mips32_hazard_ctrl: RTL and testbench

MIPS32_HAZARD_CTRL -- requirements
Module: mips32_hazard_ctrl

---
 rtl/mips32_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_mips32_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_hazard_ctrl.sv
// MIPS32 RAW hazard / flush controller with a three-entry destination scoreboard.
// Define MIPS32_HAZ_STALL_CNT_EN to add the saturating stall_cnt output.
module mips32_hazard_ctrl (
    input  logic        clk1,
    input  logic        rst,
    input  logic        start,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_wr_en,
    input  logic [4:0]  id_rd,
    input  logic        id_is_hlt,
    input  logic        branch_taken,
    output logic        stall,
    output logic        flush,
    output logic        issue,
    output logic        halted
`ifdef MIPS32_HAZ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;

    logic       ex_v;
    logic       mem_v;
    logic       wb_v;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;

    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;
    logic       sb_empty;
    logic       sb_unused;

    // WB writes before ID reads, so only EX and MEM can conflict.
    assign rs_hit = id_uses_rs && (id_rs != 5'd0) &&
                    ((ex_v && (ex_rd == id_rs)) ||
                     (mem_v && (mem_rd == id_rs)));
    assign rt_hit = id_uses_rt && (id_rt != 5'd0) &&
                    ((ex_v && (ex_rd == id_rt)) ||
                     (mem_v && (mem_rd == id_rt)));
    assign hazard = id_valid && (rs_hit || rt_hit);

    // An entry in WB is retiring this cycle, so it does not hold off HALT.
    assign sb_empty  = !ex_v && !mem_v;
    assign sb_unused = ^{wb_v, wb_rd};

    always_comb begin
        stall = 1'b1;
        flush = 1'b0;
        issue = 1'b0;
        if (state == RUN) begin
            flush = branch_taken;
            stall = hazard && !branch_taken;
            issue = id_valid && !stall && !flush;
        end
    end

    assign halted = (state == HALT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue && id_is_hlt) state_nx = DRAIN;
            DRAIN:   if (sb_empty) state_nx = HALT;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state  <= IDLE;
            ex_v   <= 1'b0;
            mem_v  <= 1'b0;
            wb_v   <= 1'b0;
            ex_rd  <= 5'd0;
            mem_rd <= 5'd0;
            wb_rd  <= 5'd0;
        end else begin
            state  <= state_nx;
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            // A flushed EX slot is squashed instead of advancing.
            mem_v  <= ex_v && !flush;
            mem_rd <= flush ? 5'd0 : ex_rd;
            ex_v   <= issue && id_wr_en && !id_is_hlt && (id_rd != 5'd0);
            ex_rd  <= issue ? id_rd : 5'd0;
        end
    end

`ifdef MIPS32_HAZ_STALL_CNT_EN
    always_ff @(posedge clk1) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if ((state == RUN) && stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Bench for mips32_hazard_ctrl: cycle-level reference model plus directed
// instruction sequences with hand-computed stall and halt expectations.
module tb_mips32_hazard_ctrl;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        id_is_hlt;
    logic        branch_taken;
    logic        stall;
    logic        flush;
    logic        issue;
    logic        halted;
`ifdef MIPS32_HAZ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mips32_hazard_ctrl dut (
        .clk1(clk1),
        .rst(rst),
        .start(start),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .id_wr_en(id_wr_en),
        .id_rd(id_rd),
        .id_is_hlt(id_is_hlt),
        .branch_taken(branch_taken),
        .stall(stall),
        .flush(flush),
        .issue(issue),
        .halted(halted)
`ifdef MIPS32_HAZ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: phase name plus the destinations written over the
    // last two accepted cycles (index 0 = one cycle ago, 0 = no writer).
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    int mst    = M_IDLE;
    int hist[$] = '{0, 0};
    int m_scnt = 0;
    bit armed  = 1'b0;
    bit e_stall, e_flush, e_issue, e_halted;

    function automatic bit reads(input bit u, input logic [4:0] r);
        return u && (r != 5'd0) &&
               ((int'(r) == hist[0]) || (int'(r) == hist[1]));
    endfunction

    task automatic compute();
        e_stall  = 1'b1;
        e_flush  = 1'b0;
        e_issue  = 1'b0;
        e_halted = (mst == M_HALT);
        if (mst == M_RUN) begin
            e_flush = branch_taken;
            e_stall = !branch_taken && id_valid &&
                      (reads(id_uses_rs, id_rs) || reads(id_uses_rt, id_rt));
            e_issue = id_valid && !e_stall && !e_flush;
        end
    endtask

    always @(negedge clk1) begin
        if (armed) begin
            compute();
            chk("cyc_stall", int'(stall), int'(e_stall));
            chk("cyc_flush", int'(flush), int'(e_flush));
            chk("cyc_issue", int'(issue), int'(e_issue));
            chk("cyc_halted", int'(halted), int'(e_halted));
`ifdef MIPS32_HAZ_STALL_CNT_EN
            chk("cyc_stall_cnt", int'(stall_cnt), m_scnt);
`endif
        end
    end

    always @(posedge clk1) begin
        if (rst) begin
            mst    = M_IDLE;
            hist   = '{0, 0};
            m_scnt = 0;
            armed  = 1'b1;
        end else if (armed) begin
            int nrd;
            if (mst == M_RUN && e_stall && m_scnt < 65535) m_scnt++;
            case (mst)
                M_IDLE:  if (start) mst = M_RUN;
                M_RUN:   if (e_issue && id_is_hlt) mst = M_DRAIN;
                M_DRAIN: if (hist[0] == 0 && hist[1] == 0) mst = M_HALT;
                default: mst = mst;
            endcase
            nrd = (e_issue && id_wr_en && !id_is_hlt && id_rd != 5'd0)
                  ? int'(id_rd) : 0;
            if (e_flush) hist[0] = 0;
            hist.push_front(nrd);
            while (hist.size() > 2) void'(hist.pop_back());
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid  = 1'b0;
        id_is_hlt = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit wr,
                        input logic [4:0] rd, input bit hlt,
                        output int stalls);
        bit got;
        got          = 1'b0;
        stalls       = 0;
        id_valid     = 1'b1;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_wr_en     = wr;
        id_rd        = rd;
        id_is_hlt    = hlt;
        branch_taken = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk1);
            if (issue) got = 1'b1;
            else if (stall) stalls++;
            tick();
        end
        id_valid  = 1'b0;
        id_is_hlt = 1'b0;
        chk("issue_seen", int'(got), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int s;
        int n;
        rst = 1'b1; start = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_wr_en = 1'b0; id_rd = '0; id_is_hlt = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;
        id_valid = 1'b1;
        @(negedge clk1);
        chk("rst_stall", int'(stall), 1);
        chk("rst_flush", int'(flush), 0);
        chk("rst_issue", int'(issue), 0);
        chk("rst_halted", int'(halted), 0);
        tick();
        id_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;

        // ADDI R1 ; ADD R4,R1,R2 back to back
        send(5'd0, 5'd0, 1, 0, 1, 5'd1, 0, s);
        chk("t1_addi_stalls", s, 0);
        send(5'd1, 5'd2, 1, 1, 1, 5'd4, 0, s);
        chk("t1_raw_stalls", s, 2);
`ifdef MIPS32_HAZ_STALL_CNT_EN
        chk("t1_stall_cnt", int'(stall_cnt), 2);
`endif
        idle(3);

        // producer R2, two independent ORs, consumer of R2
        send(5'd0, 5'd0, 1, 0, 1, 5'd2, 0, s);
        send(5'd11, 5'd12, 1, 1, 1, 5'd10, 0, s);
        chk("t2_or1_stalls", s, 0);
        send(5'd14, 5'd15, 1, 1, 1, 5'd13, 0, s);
        chk("t2_or2_stalls", s, 0);
        send(5'd2, 5'd3, 1, 1, 1, 5'd16, 0, s);
        chk("t2_consumer_stalls", s, 0);
        idle(3);

        // ADDI R0 then a reader of R0
        send(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, s);
        send(5'd0, 5'd0, 1, 1, 1, 5'd5, 0, s);
        chk("t3_r0_stalls", s, 0);
        idle(3);

        // branch taken while a RAW hazard is pending
        send(5'd0, 5'd0, 1, 0, 1, 5'd1, 0, s);
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_wr_en = 1'b1;
        id_rd = 5'd4; branch_taken = 1'b1;
        @(negedge clk1);
        chk("t4_flush", int'(flush), 1);
        chk("t4_stall", int'(stall), 0);
        chk("t4_issue", int'(issue), 0);
        tick();
        branch_taken = 1'b0;
        send(5'd1, 5'd2, 1, 1, 1, 5'd4, 0, s);
        chk("t4_after_flush_stalls", s, 0);
        idle(3);

        // ADDs in flight then HLT
        send(5'd6, 5'd7, 1, 1, 1, 5'd5, 0, s);
        send(5'd9, 5'd3, 1, 1, 1, 5'd8, 0, s);
        send(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, s);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            n++;
            @(negedge clk1);
            if (n == 1) chk("t5_drain_stall", int'(stall), 1);
            if (n == 1) chk("t5_drain_halted", int'(halted), 0);
            if (halted) break;
            tick();
        end
        chk("t5_halt_latency", n, 3);
        tick();
        id_valid = 1'b1;
        idle(2);
        @(negedge clk1);
        chk("t5_halt_held", int'(halted), 1);
        tick();

        // reset in the middle of DRAIN
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        send(5'd6, 5'd7, 1, 1, 1, 5'd9, 0, s);
        send(5'd6, 5'd7, 1, 1, 1, 5'd10, 0, s);
        send(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, s);
        rst = 1'b1;
        @(negedge clk1);
        chk("t6_in_drain", int'(halted), 0);
        tick();
        rst = 1'b0;
        id_valid = 1'b1; id_rs = 5'd10; id_uses_rs = 1'b1;
        id_uses_rt = 1'b0; id_wr_en = 1'b0; id_is_hlt = 1'b0;
        @(negedge clk1);
        chk("t6_idle_halted", int'(halted), 0);
        chk("t6_idle_stall", int'(stall), 1);
        chk("t6_idle_issue", int'(issue), 0);
        tick();
        @(negedge clk1);
        chk("t6_no_start_issue", int'(issue), 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        send(5'd10, 5'd9, 1, 1, 1, 5'd11, 0, s);
        chk("t6_resume_stalls", s, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
